fabcfg_axil_regbank: RTL and testbench
======================================

// Module: fabcfg_axil_regbank
// PURPOSE
//  Generalised AXI4-Lite configuration register bank for the FabCfg fabric-config path.
//  - Parametrised register count, data width, per-register read-only/status mapping and byte strobes.
//  - Shadow/active double-buffering with atomic commit; SLVERR on unmapped addresses.
//  - Sits between the PS AXI interconnect and fabric blocks consuming cfg_o / producing status_i.
// PARAMETERS
//  DATA_W     32     AXI data width, 32 or 64
//  ADDR_W     8      AXI byte-address width; must cover (NUM_REGS+1)*DATA_W/8 bytes
//  NUM_REGS   4      config/status registers, 1..64
//  RO_MASK    '0     NUM_REGS bits; bit i=1 -> reg i reads status_i slice i, writes ignored
//  RESET_VAL  '0     NUM_REGS*DATA_W; reset value of shadow and active, reg i at slice i
//  COMMIT_EN  1      1: cfg_o updates only on commit; 0: cfg_o follows shadow (write cycle+1)
// PORTS
//  S_AXI_ACLK      in   1                clock, all logic rising-edge
//  S_AXI_ARESETN   in   1                synchronous reset, active-low
//  S_AXI_AWADDR    in   ADDR_W           write address
//  S_AXI_AWPROT    in   3                ignored
//  S_AXI_AWVALID/AWREADY  in/out  1      AW handshake
//  S_AXI_WDATA     in   DATA_W           write data
//  S_AXI_WSTRB     in   DATA_W/8         byte enables
//  S_AXI_WVALID/WREADY    in/out  1      W handshake
//  S_AXI_BRESP     out  2                00 OKAY, 10 SLVERR
//  S_AXI_BVALID/BREADY    out/in  1      B handshake
//  S_AXI_ARADDR    in   ADDR_W           read address
//  S_AXI_ARPROT    in   3                ignored
//  S_AXI_ARVALID/ARREADY  in/out  1      AR handshake
//  S_AXI_RDATA     out  DATA_W           read data
//  S_AXI_RRESP     out  2                00 OKAY, 10 SLVERR
//  S_AXI_RVALID/RREADY    out/in  1      R handshake
//  cfg_o           out  NUM_REGS*DATA_W  active config registers
//  status_i        in   NUM_REGS*DATA_W  status inputs for RO registers; sampled on AR handshake
//  commit_pulse_o  out  1                one-cycle pulse when shadow copied to active
// BEHAVIOUR
//  - Reset (ARESETN low at edge): all ready/valid/resp/rdata/commit_pulse_o = 0.
//    shadow = active = RESET_VAL. Readies assert the first cycle after reset release.
//    Mid-transaction reset aborts the transaction; no B or R response is issued for it.
//  - Address decode: idx = addr[ADDR_W-1:$clog2(DATA_W/8)]; low address bits ignored.
//    idx < NUM_REGS        -> data register.
//    idx == NUM_REGS       -> COMMIT register.
//    idx > NUM_REGS        -> unmapped: SLVERR, no state change, rdata 0.
//  - Write FSM W_IDLE / W_RESP.
//    W_IDLE: AW and W accepted independently in either order; each latched; its ready drops once latched.
//    When both latched: write applies on the next edge, bvalid asserts the same edge, state W_RESP.
//    W_RESP: bvalid/bresp held until bready; awready = wready = 0; returns to W_IDLE on the B handshake.
//    Write latency: B valid 1 cycle after the later of the AW/W handshakes.
//  - Data register write: shadow byte k updated iff wstrb[k]. RO registers: ignored, OKAY.
//  - COMMIT write with wstrb[0] and wdata[0]=1: active <= shadow (all regs atomically);
//    commit_pulse_o = 1 the next cycle. Other data: no-op. Response OKAY.
//    When COMMIT_EN=0: active tracks shadow; commit still pulses.
//  - Read FSM R_IDLE / R_DATA.
//    R_IDLE: arready = 1; on handshake, rdata/rresp registered, rvalid = 1 next cycle.
//    R_DATA: arready = 0; rdata stable until rready, then R_IDLE.
//    Read data: RW reg -> shadow; RO reg -> status_i slice; COMMIT -> {0, COMMIT_EN}.
//  - Read and write channels are independent; one outstanding transaction each.
//    A same-cycle read of a reg being written returns the pre-write value.
// STRUCTURE
//  - fabcfg_pkg: resp enum (OKAY, SLVERR), wr/rd state enums, COMMIT_BIT constant.
//  - Single module; the address-decode function lives in fabcfg_pkg. No sub-module.
// TESTING (DATA_W=32, NUM_REGS=4, RO_MASK=4'b1000, COMMIT_EN=1)
//  1. Hold ARESETN low 20 cycles, then release -> cfg_o = RESET_VAL, valids 0;
//     awready/wready/arready = 1 on cycle 1 after release.
//  2. Write 0x1..0x3 to 0x0/0x4/0x8 -> readback matches, cfg_o unchanged.
//     Then write 0x1 to 0x10 -> commit_pulse_o one cycle; cfg_o[95:0] = {3,2,1}.
//  3. Reg1 = 0x00000002; write 0xAABBCCDD with WSTRB=4'b0010 -> read 0x0000CC02.
//  4. W presented 3 cycles before AW -> wready drops after W handshake;
//     bvalid exactly 1 cycle after AW handshake; BRESP=00; bready low 4 cycles -> bvalid held.
//  5. Write/read 0x40 -> BRESP=RRESP=2'b10, RDATA=0, all shadow/active unchanged.
//  6. status_i[127:96] = 0xDEADBEEF; write 0x5 to 0xC -> OKAY, ignored; read 0xC -> 0xDEADBEEF.
//     rready low 5 cycles -> rdata stable, arready = 0 throughout.

Source files
------------

// File: rtl/fabcfg_pkg.sv
// Shared types and helpers for the FabCfg AXI4-Lite configuration register bank.
// Contents: AXI response codes, write/read channel state encodings, register-kind
// classification and the word-index address decoder.
package fabcfg_pkg;

  // Bit of the COMMIT register that requests a shadow-to-active copy
  localparam int unsigned COMMIT_BIT = 0;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'b00,
    RESP_SLVERR = 2'b10
  } resp_e;

  typedef enum logic {
    W_IDLE,
    W_RESP
  } wr_state_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rd_state_e;

  typedef enum logic [1:0] {
    KIND_DATA,
    KIND_COMMIT,
    KIND_UNMAPPED
  } reg_kind_e;

  // Classify a word index: data registers first, COMMIT right after, rest unmapped
  function automatic reg_kind_e decode_idx(input int unsigned idx, input int unsigned num_regs);
    reg_kind_e kind;
    if (idx < num_regs) begin
      kind = KIND_DATA;
    end else if (idx == num_regs) begin
      kind = KIND_COMMIT;
    end else begin
      kind = KIND_UNMAPPED;
    end
    return kind;
  endfunction

endpackage

// File: rtl/fabcfg_axil_regbank.sv
// AXI4-Lite configuration register bank with shadow/active double buffering.
// Software writes land in the shadow copy; a write of 1 to the COMMIT register
// (the word right after the last data register) copies every shadow register to
// the active copy in one edge, which drives cfg_o. RO registers read status_i.
// Ports:
//   S_AXI_ACLK / S_AXI_ARESETN  clock, synchronous active-low reset
//   S_AXI_AW* / W* / B*         AXI4-Lite write address, data, response channels
//   S_AXI_AR* / R*              AXI4-Lite read address, data channels
//   cfg_o                       active config registers, reg i at slice i
//   status_i                    status words for RO registers, sampled on AR handshake
//   commit_pulse_o              one-cycle pulse when shadow is copied to active
module fabcfg_axil_regbank
  import fabcfg_pkg::*;
#(
  parameter int unsigned                   DATA_W    = 32,
  parameter int unsigned                   ADDR_W    = 8,
  parameter int unsigned                   NUM_REGS  = 4,
  parameter logic [NUM_REGS-1:0]           RO_MASK   = '0,
  parameter logic [NUM_REGS*DATA_W-1:0]    RESET_VAL = '0,
  parameter bit                            COMMIT_EN = 1'b1
) (
  input  logic                         S_AXI_ACLK,
  input  logic                         S_AXI_ARESETN,
  input  logic [ADDR_W-1:0]            S_AXI_AWADDR,
  input  logic [2:0]                   S_AXI_AWPROT,
  input  logic                         S_AXI_AWVALID,
  output logic                         S_AXI_AWREADY,
  input  logic [DATA_W-1:0]            S_AXI_WDATA,
  input  logic [DATA_W/8-1:0]          S_AXI_WSTRB,
  input  logic                         S_AXI_WVALID,
  output logic                         S_AXI_WREADY,
  output logic [1:0]                   S_AXI_BRESP,
  output logic                         S_AXI_BVALID,
  input  logic                         S_AXI_BREADY,
  input  logic [ADDR_W-1:0]            S_AXI_ARADDR,
  input  logic [2:0]                   S_AXI_ARPROT,
  input  logic                         S_AXI_ARVALID,
  output logic                         S_AXI_ARREADY,
  output logic [DATA_W-1:0]            S_AXI_RDATA,
  output logic [1:0]                   S_AXI_RRESP,
  output logic                         S_AXI_RVALID,
  input  logic                         S_AXI_RREADY,
  output logic [NUM_REGS*DATA_W-1:0]   cfg_o,
  input  logic [NUM_REGS*DATA_W-1:0]   status_i,
  output logic                         commit_pulse_o
);

  localparam int unsigned STRB_W   = DATA_W / 8;
  localparam int unsigned BYTE_LSB = $clog2(STRB_W);
  localparam int unsigned IDX_W    = ADDR_W - BYTE_LSB;

  logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] active_q;
  logic [NUM_REGS-1:0][DATA_W-1:0] status_arr;
  logic                            commit_pulse_q;

  // Write channel state
  wr_state_e           wr_state_q, wr_state_nxt;
  logic                awready_q, awready_nxt;
  logic                wready_q, wready_nxt;
  logic                bvalid_q, bvalid_nxt;
  resp_e               bresp_q, bresp_nxt;
  logic                aw_lat_q, aw_lat_nxt;
  logic                w_lat_q, w_lat_nxt;
  logic [ADDR_W-1:0]   aw_addr_q;
  logic [DATA_W-1:0]   w_data_q;
  logic [STRB_W-1:0]   w_strb_q;
  logic                aw_hs, w_hs, wr_fire, commit_hit;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W-1:0]   wr_data;
  logic [STRB_W-1:0]   wr_strb;
  logic [IDX_W-1:0]    wr_idx;
  reg_kind_e           wr_kind;

  // Read channel state
  rd_state_e           rd_state_q, rd_state_nxt;
  logic                arready_q, arready_nxt;
  logic                rvalid_q, rvalid_nxt;
  logic [DATA_W-1:0]   rdata_q, rdata_nxt;
  resp_e               rresp_q, rresp_nxt;
  logic                ar_hs;
  logic [IDX_W-1:0]    rd_idx;
  reg_kind_e           rd_kind;
  logic [DATA_W-1:0]   rd_data_c;
  resp_e               rd_resp_c;

  logic unused_ok;

  assign status_arr = status_i;

  // Write address/data: a beat handshaking this cycle takes precedence over a latched one
  assign aw_hs   = S_AXI_AWVALID & awready_q;
  assign w_hs    = S_AXI_WVALID & wready_q;
  assign wr_addr = aw_hs ? S_AXI_AWADDR : aw_addr_q;
  assign wr_data = w_hs ? S_AXI_WDATA : w_data_q;
  assign wr_strb = w_hs ? S_AXI_WSTRB : w_strb_q;
  assign wr_idx  = wr_addr[ADDR_W-1:BYTE_LSB];
  assign wr_kind = decode_idx(32'(wr_idx), NUM_REGS);

  assign commit_hit = wr_fire && (wr_kind == KIND_COMMIT) && wr_strb[0] && wr_data[COMMIT_BIT];

  assign ar_hs   = S_AXI_ARVALID & arready_q;
  assign rd_idx  = S_AXI_ARADDR[ADDR_W-1:BYTE_LSB];
  assign rd_kind = decode_idx(32'(rd_idx), NUM_REGS);

  // Write FSM next-state and registered-output values
  always_comb begin
    wr_state_nxt = wr_state_q;
    awready_nxt  = awready_q;
    wready_nxt   = wready_q;
    bvalid_nxt   = bvalid_q;
    bresp_nxt    = bresp_q;
    aw_lat_nxt   = aw_lat_q;
    w_lat_nxt    = w_lat_q;
    wr_fire      = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        aw_lat_nxt  = aw_lat_q | aw_hs;
        w_lat_nxt   = w_lat_q | w_hs;
        awready_nxt = ~(aw_lat_q | aw_hs);
        wready_nxt  = ~(w_lat_q | w_hs);
        if ((aw_lat_q | aw_hs) && (w_lat_q | w_hs)) begin
          wr_fire      = 1'b1;
          aw_lat_nxt   = 1'b0;
          w_lat_nxt    = 1'b0;
          bvalid_nxt   = 1'b1;
          bresp_nxt    = (wr_kind == KIND_UNMAPPED) ? RESP_SLVERR : RESP_OKAY;
          wr_state_nxt = W_RESP;
        end
      end
      W_RESP: begin
        awready_nxt = 1'b0;
        wready_nxt  = 1'b0;
        if (S_AXI_BREADY) begin
          bvalid_nxt   = 1'b0;
          awready_nxt  = 1'b1;
          wready_nxt   = 1'b1;
          wr_state_nxt = W_IDLE;
        end
      end
      default: wr_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      bvalid_q   <= 1'b0;
      bresp_q    <= RESP_OKAY;
      aw_lat_q   <= 1'b0;
      w_lat_q    <= 1'b0;
    end else begin
      wr_state_q <= wr_state_nxt;
      awready_q  <= awready_nxt;
      wready_q   <= wready_nxt;
      bvalid_q   <= bvalid_nxt;
      bresp_q    <= bresp_nxt;
      aw_lat_q   <= aw_lat_nxt;
      w_lat_q    <= w_lat_nxt;
    end
  end

  // Register storage: byte-strobed shadow writes, atomic commit into active
  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      shadow_q       <= RESET_VAL;
      active_q       <= RESET_VAL;
      commit_pulse_q <= 1'b0;
      aw_addr_q      <= '0;
      w_data_q       <= '0;
      w_strb_q       <= '0;
    end else begin
      commit_pulse_q <= commit_hit;
      if (aw_hs) begin
        aw_addr_q <= S_AXI_AWADDR;
      end
      if (w_hs) begin
        w_data_q <= S_AXI_WDATA;
        w_strb_q <= S_AXI_WSTRB;
      end
      if (wr_fire && (wr_kind == KIND_DATA)) begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if ((wr_idx == IDX_W'(i)) && !RO_MASK[i]) begin
            for (int unsigned b = 0; b < STRB_W; b++) begin
              if (wr_strb[b]) begin
                shadow_q[i][8*b +: 8] <= wr_data[8*b +: 8];
              end
            end
          end
        end
      end
      // Without commit gating the active copy trails shadow by one cycle
      if (COMMIT_EN) begin
        if (commit_hit) begin
          active_q <= shadow_q;
        end
      end else begin
        active_q <= shadow_q;
      end
    end
  end

  // Read data mux; shadow is read before any same-edge write lands
  always_comb begin
    rd_data_c = '0;
    rd_resp_c = RESP_OKAY;
    case (rd_kind)
      KIND_DATA: begin
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
          if (rd_idx == IDX_W'(i)) begin
            rd_data_c = RO_MASK[i] ? status_arr[i] : shadow_q[i];
          end
        end
      end
      KIND_COMMIT: rd_data_c = DATA_W'(COMMIT_EN);
      default:     rd_resp_c = RESP_SLVERR;
    endcase
  end

  // Read FSM next-state and registered-output values
  always_comb begin
    rd_state_nxt = rd_state_q;
    arready_nxt  = arready_q;
    rvalid_nxt   = rvalid_q;
    rdata_nxt    = rdata_q;
    rresp_nxt    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        arready_nxt = 1'b1;
        if (ar_hs) begin
          arready_nxt  = 1'b0;
          rvalid_nxt   = 1'b1;
          rdata_nxt    = rd_data_c;
          rresp_nxt    = rd_resp_c;
          rd_state_nxt = R_DATA;
        end
      end
      R_DATA: begin
        arready_nxt = 1'b0;
        if (S_AXI_RREADY) begin
          rvalid_nxt   = 1'b0;
          arready_nxt  = 1'b1;
          rd_state_nxt = R_IDLE;
        end
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (!S_AXI_ARESETN) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= RESP_OKAY;
    end else begin
      rd_state_q <= rd_state_nxt;
      arready_q  <= arready_nxt;
      rvalid_q   <= rvalid_nxt;
      rdata_q    <= rdata_nxt;
      rresp_q    <= rresp_nxt;
    end
  end

  assign S_AXI_AWREADY  = awready_q;
  assign S_AXI_WREADY   = wready_q;
  assign S_AXI_BVALID   = bvalid_q;
  assign S_AXI_BRESP    = bresp_q;
  assign S_AXI_ARREADY  = arready_q;
  assign S_AXI_RVALID   = rvalid_q;
  assign S_AXI_RDATA    = rdata_q;
  assign S_AXI_RRESP    = rresp_q;
  assign cfg_o          = active_q;
  assign commit_pulse_o = commit_pulse_q;

  // Protection bits and sub-word address bits carry no meaning here
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                       wr_addr[BYTE_LSB-1:0], S_AXI_ARADDR[BYTE_LSB-1:0]};

endmodule

// File: tb/tb_fabcfg_axil_regbank.sv
// Directed self-checking bench for fabcfg_axil_regbank (32-bit, 4 regs, reg3 RO).
module tb_fabcfg_axil_regbank;

  localparam logic [127:0] RV = 128'h44444444_33333333_22222222_11111111;

  logic         clk;
  logic         aresetn;
  logic [7:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [7:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] cfg_o;
  logic [127:0] status_i;
  logic         commit_pulse_o;

  int total;
  int bad;
  int pulse_cnt;

  fabcfg_axil_regbank #(
    .DATA_W    (32),
    .ADDR_W    (8),
    .NUM_REGS  (4),
    .RO_MASK   (4'b1000),
    .RESET_VAL (RV),
    .COMMIT_EN (1'b1)
  ) dut (
    .S_AXI_ACLK     (clk),
    .S_AXI_ARESETN  (aresetn),
    .S_AXI_AWADDR   (awaddr),
    .S_AXI_AWPROT   (awprot),
    .S_AXI_AWVALID  (awvalid),
    .S_AXI_AWREADY  (awready),
    .S_AXI_WDATA    (wdata),
    .S_AXI_WSTRB    (wstrb),
    .S_AXI_WVALID   (wvalid),
    .S_AXI_WREADY   (wready),
    .S_AXI_BRESP    (bresp),
    .S_AXI_BVALID   (bvalid),
    .S_AXI_BREADY   (bready),
    .S_AXI_ARADDR   (araddr),
    .S_AXI_ARPROT   (arprot),
    .S_AXI_ARVALID  (arvalid),
    .S_AXI_ARREADY  (arready),
    .S_AXI_RDATA    (rdata),
    .S_AXI_RRESP    (rresp),
    .S_AXI_RVALID   (rvalid),
    .S_AXI_RREADY   (rready),
    .cfg_o          (cfg_o),
    .status_i       (status_i),
    .commit_pulse_o (commit_pulse_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (commit_pulse_o) pulse_cnt++;
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    bit aw_done = 1'b0;
    bit w_done  = 1'b0;
    int n = 0;
    @(negedge clk);
    awaddr = a; awvalid = 1'b1;
    wdata = d; wstrb = s; wvalid = 1'b1;
    bready = 1'b1;
    while (!(aw_done && w_done) && n < 50) begin
      if (awvalid && awready) aw_done = 1'b1;
      if (wvalid && wready) w_done = 1'b1;
      @(negedge clk);
      if (aw_done) awvalid = 1'b0;
      if (w_done) wvalid = 1'b0;
      n++;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    chk("wr_handshakes", {126'd0, aw_done, w_done}, 128'd3);
    n = 0;
    while (!bvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("wr_bvalid", bvalid, 1);
    resp = bresp;
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n = 0;
    @(negedge clk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    while (!arready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rd_arready", arready, 1);
    @(negedge clk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("rd_rvalid", rvalid, 1);
    d = rdata;
    r = rresp;
    @(negedge clk);
    rready = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  resp;
    logic [31:0] d;
    int          p0;
    int          held;
    int          stable;

    total = 0; bad = 0; pulse_cnt = 0;
    aresetn = 1'b0;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    status_i = '0;

    // 1. reset
    repeat (20) @(negedge clk);
    chk("rst_awready", awready, 0);
    chk("rst_arready", arready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_cfg", cfg_o, RV);
    aresetn = 1'b1;
    @(negedge clk);
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);
    chk("rel_pulse", commit_pulse_o, 0);

    // 2. shadow writes then commit
    axi_write(8'h00, 32'h1, 4'hF, resp); chk("w0_resp", resp, 0);
    axi_write(8'h04, 32'h2, 4'hF, resp); chk("w1_resp", resp, 0);
    axi_write(8'h08, 32'h3, 4'hF, resp); chk("w2_resp", resp, 0);
    axi_read(8'h00, d, resp); chk("r0", d, 32'h1);
    axi_read(8'h04, d, resp); chk("r1", d, 32'h2);
    axi_read(8'h08, d, resp); chk("r2", d, 32'h3); chk("r2_resp", resp, 0);
    chk("cfg_precommit", cfg_o, RV);
    p0 = pulse_cnt;
    axi_write(8'h10, 32'h1, 4'h1, resp); chk("commit_resp", resp, 0);
    @(negedge clk);
    chk("commit_pulses", pulse_cnt - p0, 1);
    chk("cfg_commit", cfg_o, 128'h44444444_00000003_00000002_00000001);
    axi_read(8'h10, d, resp); chk("commit_rd", d, 32'h1);

    // 3. byte strobes
    axi_write(8'h04, 32'hAABBCCDD, 4'b0010, resp); chk("strb_resp", resp, 0);
    axi_read(8'h04, d, resp); chk("strb_rd", d, 32'h0000CC02);

    // 4. W ahead of AW, B backpressure
    @(negedge clk);
    wdata = 32'h12345678; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b0;
    @(negedge clk);
    wvalid = 1'b0;
    chk("t4_wready_drop", wready, 0);
    chk("t4_awready_wait", awready, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t4_bvalid_early", bvalid, 0);
    awaddr = 8'h00; awvalid = 1'b1;
    @(negedge clk);
    awvalid = 1'b0;
    chk("t4_bvalid_lat", bvalid, 1);
    chk("t4_bresp", bresp, 0);
    held = 0;
    repeat (4) begin
      @(negedge clk);
      if (bvalid && !awready && !wready) held++;
    end
    chk("t4_bvalid_held", held, 4);
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    chk("t4_bvalid_clear", bvalid, 0);
    chk("t4_awready_back", awready, 1);
    axi_read(8'h00, d, resp); chk("t4_rd", d, 32'h12345678);
    chk("t4_cfg_hold", cfg_o[31:0], 32'h1);

    // 5. unmapped addresses
    axi_write(8'h40, 32'hFFFFFFFF, 4'hF, resp); chk("unm_bresp", resp, 2'b10);
    axi_read(8'h40, d, resp); chk("unm_rresp", resp, 2'b10); chk("unm_rdata", d, 0);
    axi_read(8'h14, d, resp); chk("unm14_rresp", resp, 2'b10);
    axi_read(8'h00, d, resp); chk("unm_r0", d, 32'h12345678);
    axi_read(8'h08, d, resp); chk("unm_r2", d, 32'h3);
    chk("unm_cfg", cfg_o, 128'h44444444_00000003_00000002_00000001);

    // 6. RO register
    status_i = {32'hDEADBEEF, 96'd0};
    axi_write(8'h0C, 32'h5, 4'hF, resp); chk("ro_bresp", resp, 0);
    axi_read(8'h0C, d, resp); chk("ro_rd", d, 32'hDEADBEEF); chk("ro_rresp", resp, 0);
    @(negedge clk);
    araddr = 8'h0C; arvalid = 1'b1; rready = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    status_i = {32'h01234567, 96'd0};
    chk("ro_rvalid", rvalid, 1);
    chk("ro_arready_low", arready, 0);
    stable = 0;
    repeat (5) begin
      @(negedge clk);
      if (rvalid && rdata == 32'hDEADBEEF && !arready) stable++;
    end
    chk("ro_rdata_stable", stable, 5);
    rready = 1'b1;
    @(negedge clk);
    rready = 1'b0;
    chk("ro_rvalid_clear", rvalid, 0);

    // Commit with data bit 0 clear is a no-op; a real commit picks up new shadow
    p0 = pulse_cnt;
    axi_write(8'h10, 32'h0, 4'hF, resp); chk("nocommit_resp", resp, 0);
    @(negedge clk);
    chk("nocommit_pulses", pulse_cnt - p0, 0);
    chk("nocommit_cfg", cfg_o, 128'h44444444_00000003_00000002_00000001);
    axi_write(8'h10, 32'h1, 4'hF, resp);
    @(negedge clk);
    chk("commit2_pulses", pulse_cnt - p0, 1);
    chk("commit2_cfg", cfg_o, 128'h44444444_00000003_0000CC02_12345678);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
